pipe_stage_fifo: RTL and testbench

Parametrised elastic pipeline-stage buffer; successor to the fixed single-entry stage registers between IF, ID, EXE, MEM and WB. Holds up to DEPTH stage payloads (PC, instruction, control and operand fields packed into one DATA_W vector) behind a valid/ready handshake. Supports pipeline freeze and branch flush, plus an optional zero-latency fall-through mode. Sits between any two pipeline stages; the producer stage drives the input side and the consumer stage drives the output side.

---
 rtl/pipe_stage_fifo.sv | 105 ++++++++++
 tb/tb_pipe_stage_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic buffer between two pipeline stages.
// Circular buffer of DEPTH payloads behind a valid/ready handshake, with
// freeze (stall), flush (branch discard) and an optional fall-through path
// that hands a payload straight to the consumer when the buffer is empty.
module pipe_stage_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  // A single-entry buffer still needs a one-bit pointer to index storage.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam bit               FALL_THRU = (MODE == 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic empty, full;
  logic bypass_avail, bypass_take;
  logic push_raw, pop_raw, push, pop;
  logic [DATA_W-1:0] head_data;

  // Wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // in_ready looks only at registered state and freeze, never at out_ready,
  // so a full buffer refuses input even when it is being drained.
  assign in_ready = rst & ~freeze & ~full;

  // Fall-through: an empty buffer presents the incoming payload directly.
  assign bypass_avail = FALL_THRU & empty & in_valid;
  assign out_valid    = rst & ~freeze & (~empty | bypass_avail);
  assign head_data    = empty ? in_data : mem_q[rd_ptr_q];
  assign out_data     = out_valid ? head_data : '0;
  assign count        = count_q;

  // A bypassed payload is consumed in flight: neither stored nor popped.
  assign push_raw    = in_valid & in_ready & ~flush;
  assign pop_raw     = out_valid & out_ready & ~flush;
  assign bypass_take = pop_raw & empty;
  assign push        = push_raw & ~bypass_take;
  assign pop         = pop_raw & ~empty;

  // Next-state for pointers and occupancy; flush wins over everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state: cleared asynchronously, updated on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Handshake rules make overflow and underflow impossible.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: drives two buffer instances (DEPTH=3 registered and
// DEPTH=2 fall-through) from shared stimulus; a queue-level reference model
// records accepted payloads and a negedge monitor checks every output.
module tb_pipe_stage_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  c0, c1;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(32), .DEPTH(3), .MODE(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .count(c0)
  );

  pipe_stage_fifo #(.DATA_W(32), .DEPTH(2), .MODE(1)) u_ft (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(c1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: ordered list of stored payloads per instance.
  logic [31:0] mq [2][4];
  int          msz [2];

  function automatic int dep(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic bit fall(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", k, name, act, expv, $time);
    end
  endtask

  // Model update at each edge: flush/reset clear, else pop head and append accepted payload.
  initial begin
    msz[0] = 0;
    msz[1] = 0;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit rdy, vld, byp;
        if (!rst || flush) begin
          msz[k] = 0;
        end else begin
          rdy = !freeze && (msz[k] < dep(k));
          vld = !freeze && (msz[k] > 0 || (fall(k) && in_valid));
          byp = fall(k) && msz[k] == 0 && in_valid && !freeze && out_ready;
          if (vld && out_ready && msz[k] > 0) begin
            for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
            msz[k] = msz[k] - 1;
          end
          if (in_valid && rdy && !byp) begin
            mq[k][msz[k]] = in_data;
            msz[k] = msz[k] + 1;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle.
  always @(negedge clk) begin
    logic        a_ir, a_ov, e_ir, e_ov;
    logic [31:0] a_od, e_od;
    logic [1:0]  a_c, e_c;
    for (int k = 0; k < 2; k++) begin
      a_ir = (k == 0) ? ir0 : ir1;
      a_ov = (k == 0) ? ov0 : ov1;
      a_od = (k == 0) ? od0 : od1;
      a_c  = (k == 0) ? c0  : c1;
      if (!rst) begin
        e_ir = 1'b0; e_ov = 1'b0; e_od = '0; e_c = '0;
      end else begin
        e_ir = !freeze && (msz[k] < dep(k));
        e_ov = !freeze && (msz[k] > 0 || (fall(k) && in_valid));
        e_od = !e_ov ? 32'h0 : (msz[k] > 0 ? mq[k][0] : in_data);
        e_c  = 2'(msz[k]);
      end
      chk("in_ready",  k, {31'b0, a_ir}, {31'b0, e_ir});
      chk("out_valid", k, {31'b0, a_ov}, {31'b0, e_ov});
      chk("out_data",  k, a_od, e_od);
      chk("count",     k, {30'b0, a_c}, {30'b0, e_c});
      if (rst && !flush && a_ov && out_ready)
        $display("[TB] inst%0d transfer data=%h count=%0d", k, a_od, a_c);
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single transfer.
    step(1'b1, 32'hDEADBEEF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Fill to full with consumer stalled, then drain while refilling.
    step(1'b1, 32'h1, 1'b0);
    step(1'b1, 32'h2, 1'b0);
    step(1'b1, 32'h3, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    step(1'b1, 32'h4, 1'b1);
    step(1'b1, 32'h4, 1'b1);
    step(1'b1, 32'h5, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Simultaneous push and pop at count 1.
    step(1'b1, 32'h9, 1'b0);
    step(1'b1, 32'hA, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Flush with contents and a same-cycle push.
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    flush = 1'b1;
    step(1'b1, 32'h77, 1'b0);
    flush = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Freeze for three cycles with both sides requesting.
    step(1'b1, 32'h33, 1'b0);
    step(1'b1, 32'h44, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h66, 1'b1);
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // Fall-through when empty, consumed and then held.
    step(1'b1, 32'h55, 1'b1);
    step(1'b1, 32'h55, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Randomized traffic with occasional flush, freeze and mid-run reset.
    for (int n = 0; n < 800; n++) begin
      flush  = ($urandom_range(0, 99) < 3);
      freeze = ($urandom_range(0, 99) < 8);
      rst    = !($urandom_range(0, 199) == 0);
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60);
      rst = 1'b1;
    end
    flush  = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
